// File: rtl/fe_pkg.sv
// Front-end shared types for the RV32I decode stage: opcodes, mnemonics, immediate formats,
// queue entry and decode FSM state.
package fe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK,
    INVALID
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} RV32I_IMM_FMT_t;

  typedef enum logic {RUN, HALT} RV32I_DECODE_STATE_t;

  // Width-independent part of a queue word; immediate and PC are stored beside it.
  typedef struct packed {
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    logic                        illegal;
  } rv32i_dec_entry_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: instruction bits [31:7] + format -> sign-extended XLEN value.
module rv32i_imm_gen
  import fe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]      raw,
  input  RV32I_IMM_FMT_t   fmt,
  output logic [XLEN-1:0]  imm
);

  logic [31:0] v;

  always_comb begin
    case (fmt)
      IMM_I:   v = {{20{raw[31]}}, raw[31:20]};
      IMM_S:   v = {{20{raw[31]}}, raw[31:25], raw[11:7]};
      IMM_B:   v = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
      IMM_U:   v = {raw[31:12], 12'b0};
      IMM_J:   v = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
      default: v = '0;
    endcase
    // Replicate bit 31 so XLEN == 32 needs no zero-width replication.
    imm = {{(XLEN-31){v[31]}}, v[30:0]};
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage with a DEPTH-entry output queue and flush.
// Optional feature macro: RV32I_DECODE_ILLEGAL_EN (illegal flagging + RUN/HALT FSM).
module rv32i_decode_stage
  import fe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [PC_WIDTH-1:0]         in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output RV32I_INSTRUCTION_MNEMONIC_t out_mnemonic,
  output logic [2:0]                  out_funct3,
  output logic [6:0]                  out_funct7,
  output logic [4:0]                  out_rs1,
  output logic [4:0]                  out_rs2,
  output logic [4:0]                  out_rd,
  output logic [XLEN-1:0]             out_imm,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic                        out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  RV32I_INSTRUCTION_MNEMONIC_t mn;
  RV32I_IMM_FMT_t fmt;
  logic use_rs1, use_rs2, use_rd, use_f3, use_f7;
  rv32i_dec_entry_t dec;
  logic [XLEN-1:0] dec_imm;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    mn = INVALID;
    fmt = IMM_NONE;
    {use_rs1, use_rs2, use_rd, use_f3, use_f7} = '0;
    case (opc)
      OP_LUI:   begin mn = LUI;   fmt = IMM_U; use_rd = 1'b1; end
      OP_AUIPC: begin mn = AUIPC; fmt = IMM_U; use_rd = 1'b1; end
      OP_JAL:   begin mn = JAL;   fmt = IMM_J; use_rd = 1'b1; end
      OP_JALR: begin
        if (f3 == 3'd0) mn = JALR;
        fmt = IMM_I; {use_rd, use_rs1, use_f3} = '1;
      end
      OP_BRANCH: begin
        case (f3)
          3'd0: mn = BEQ;  3'd1: mn = BNE;  3'd4: mn = BLT;
          3'd5: mn = BGE;  3'd6: mn = BLTU; 3'd7: mn = BGEU;
          default: mn = INVALID;
        endcase
        fmt = IMM_B; {use_rs1, use_rs2, use_f3} = '1;
      end
      OP_LOAD: begin
        case (f3)
          3'd0: mn = LB; 3'd1: mn = LH; 3'd2: mn = LW; 3'd4: mn = LBU; 3'd5: mn = LHU;
          default: mn = INVALID;
        endcase
        fmt = IMM_I; {use_rd, use_rs1, use_f3} = '1;
      end
      OP_STORE: begin
        case (f3)
          3'd0: mn = SB; 3'd1: mn = SH; 3'd2: mn = SW;
          default: mn = INVALID;
        endcase
        fmt = IMM_S; {use_rs1, use_rs2, use_f3} = '1;
      end
      OP_IMM: begin
        case (f3)
          3'd0: mn = ADDI; 3'd2: mn = SLTI; 3'd3: mn = SLTIU;
          3'd4: mn = XORI; 3'd6: mn = ORI;  3'd7: mn = ANDI;
          3'd1: mn = (f7 == 7'h00) ? SLLI : INVALID;
          default: mn = (f7 == 7'h00) ? SRLI : (f7 == 7'h20) ? SRAI : INVALID;
        endcase
        fmt = IMM_I; {use_rd, use_rs1, use_f3} = '1;
        use_f7 = (f3 == 3'd1) || (f3 == 3'd5);
      end
      OP_REG: begin
        case ({f7, f3})
          {7'h00, 3'd0}: mn = ADD;  {7'h20, 3'd0}: mn = SUB;
          {7'h00, 3'd1}: mn = SLL;  {7'h00, 3'd2}: mn = SLT;
          {7'h00, 3'd3}: mn = SLTU; {7'h00, 3'd4}: mn = XOR;
          {7'h00, 3'd5}: mn = SRL;  {7'h20, 3'd5}: mn = SRA;
          {7'h00, 3'd6}: mn = OR;   {7'h00, 3'd7}: mn = AND;
          default:       mn = INVALID;
        endcase
        {use_rd, use_rs1, use_rs2, use_f3, use_f7} = '1;
      end
      OP_FENCE: begin
        if (f3 == 3'd0) mn = FENCE;
        fmt = IMM_I; {use_rd, use_rs1, use_f3} = '1;
      end
      OP_SYSTEM: begin
        if (in_instr[31:7] == 25'd0) mn = ECALL;
        else if (in_instr[31:7] == {12'h001, 13'd0}) mn = EBREAK;
        fmt = IMM_I; {use_rd, use_rs1, use_f3} = '1;
      end
      default: mn = INVALID;
    endcase
    // Anything undecodable carries no operand fields at all.
    if (mn == INVALID) begin
      fmt = IMM_NONE;
      {use_rs1, use_rs2, use_rd, use_f3, use_f7} = '0;
    end
  end

  rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .raw (in_instr[31:7]),
    .fmt (fmt),
    .imm (dec_imm)
  );

  always_comb begin
    dec          = '0;
    dec.mnemonic = mn;
    dec.funct3   = use_f3  ? f3               : 3'd0;
    dec.funct7   = use_f7  ? f7               : 7'd0;
    dec.rs1      = use_rs1 ? in_instr[19:15]  : 5'd0;
    dec.rs2      = use_rs2 ? in_instr[24:20]  : 5'd0;
    dec.rd       = use_rd  ? in_instr[11:7]   : 5'd0;
`ifdef RV32I_DECODE_ILLEGAL_EN
    dec.illegal  = (mn == INVALID);
`else
    dec.illegal  = 1'b0;
`endif
  end

  rv32i_dec_entry_t    ent_q [DEPTH];
  logic [XLEN-1:0]     imm_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_q  [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr] <= dec;
        imm_q[wr_ptr] <= dec_imm;
        pc_q[wr_ptr]  <= in_pc;
        wr_ptr        <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef RV32I_DECODE_ILLEGAL_EN
  RV32I_DECODE_STATE_t state;

  // Accepting an illegal instruction stalls fetch until a redirect arrives.
  always_ff @(posedge clk) begin
    if (rst || flush) state <= RUN;
    else begin
      case (state)
        RUN:     if (push && dec.illegal) state <= HALT;
        default: state <= state;
      endcase
    end
  end

  assign in_ready = (count < DEPTH_C) && (state == RUN);
`else
  assign in_ready = (count < DEPTH_C);
`endif

  assign out_valid    = (count != '0);
  assign out_mnemonic = ent_q[rd_ptr].mnemonic;
  assign out_funct3   = ent_q[rd_ptr].funct3;
  assign out_funct7   = ent_q[rd_ptr].funct7;
  assign out_rs1      = ent_q[rd_ptr].rs1;
  assign out_rs2      = ent_q[rd_ptr].rs2;
  assign out_rd       = ent_q[rd_ptr].rd;
  assign out_illegal  = ent_q[rd_ptr].illegal;
  assign out_imm      = imm_q[rd_ptr];
  assign out_pc       = pc_q[rd_ptr];

endmodule
